// File: rtl/multiword_arith_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multiword_arith_ctrl_pkg
// Shared definitions for the multi-word add/subtract controller:
//   - WORD_W_DEF / MAX_WORDS_DEF : default slice width and operand length
//   - NWORDS_W                   : width of the nwords (length minus one) field
//   - state_e                    : controller FSM states
// ----------------------------------------------------------------------------
package multiword_arith_ctrl_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int MAX_WORDS_DEF = 4;
  localparam int NWORDS_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multiword_arith_ctrl_if.sv
// ----------------------------------------------------------------------------
// multiword_arith_ctrl_if
// Request/result bundle of the multi-word arithmetic controller.
//   master : drives start, op_sub, nwords, a_in, b_in; observes the results
//   slave  : the controller; drives busy, done, result, carry, ovf
// ----------------------------------------------------------------------------
interface multiword_arith_ctrl_if
  import multiword_arith_ctrl_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
);
  localparam int RES_W = WORD_W * MAX_WORDS;

  logic                start;
  logic                op_sub;
  logic [NWORDS_W-1:0] nwords;
  logic [RES_W-1:0]    a_in;
  logic [RES_W-1:0]    b_in;
  logic                busy;
  logic                done;
  logic [RES_W-1:0]    result;
  logic                carry;
  logic                ovf;

  modport master (
    output start, op_sub, nwords, a_in, b_in,
    input  busy, done, result, carry, ovf
  );

  modport slave (
    input  start, op_sub, nwords, a_in, b_in,
    output busy, done, result, carry, ovf
  );

endinterface

// File: rtl/multiword_arith_ctrl_arith_word_slice.sv
// ----------------------------------------------------------------------------
// arith_word_slice
// One WORD_W-bit combinational adder slice. For subtraction the b operand is
// inverted here; the +1 of two's complement arrives through cin.
//   a, b : operand words        cin  : carry in from the previous word
//   sub  : 1 = a - b            sum  : result word     cout : carry out
// ----------------------------------------------------------------------------
module arith_word_slice #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/multiword_arith_ctrl.sv
// ----------------------------------------------------------------------------
// multiword_arith_ctrl
// Sequential multi-word add/subtract: one word per clock, least-significant
// word first, through a single reused arith_word_slice.
//   clk   : clock (rising edge)     rst_n : async active-low reset
//   bus   : multiword_arith_ctrl_if.slave (start/op_sub/nwords/a_in/b_in in,
//           busy/done/result/carry/ovf out)
// Optional build macro MULTIWORD_ARITH_CTRL_SAT_EN: on signed overflow the
// result is replaced by the active-width signed extreme.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// EXEC  | processing word idx, one word per clock
// DONE  | last word stored; done pulses on the following cycle
// ----------------------------------------------------------------------------
module multiword_arith_ctrl
  import multiword_arith_ctrl_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multiword_arith_ctrl_if.slave       bus
);

  localparam int RES_W = WORD_W * MAX_WORDS;

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [NWORDS_W-1:0] nw_q, nw_d;
  logic [NWORDS_W-1:0] idx_q, idx_d;
  logic [RES_W-1:0]    a_q, a_d;
  logic [RES_W-1:0]    b_q, b_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                chain_q, chain_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy_w;

  logic [WORD_W-1:0]   a_word, b_word, sum_word;
  logic                cout_w, last_w, ovf_w;

`ifdef MULTIWORD_ARITH_CTRL_SAT_EN
  // Signed extreme over words 0..nw; words above nw stay zero.
  function automatic logic [RES_W-1:0] sat_value(input logic [NWORDS_W-1:0] nw,
                                                 input logic neg);
    logic [RES_W-1:0] v;
    v = '0;
    for (int w = 0; w < MAX_WORDS; w++) begin
      if (w <= int'(nw)) v[w*WORD_W +: WORD_W] = neg ? '0 : '1;
    end
    v[int'(nw)*WORD_W + WORD_W - 1] = neg;
    return v;
  endfunction
`endif

  assign a_word = a_q[int'(idx_q)*WORD_W +: WORD_W];
  assign b_word = b_q[int'(idx_q)*WORD_W +: WORD_W];
  assign last_w = (idx_q == nw_q);
  assign ovf_w  = ~(a_word[WORD_W-1] ^ b_word[WORD_W-1] ^ op_q) &
                   (a_word[WORD_W-1] ^ sum_word[WORD_W-1]);

  arith_word_slice #(.WORD_W(WORD_W)) u_slice (
    .a    (a_word),
    .b    (b_word),
    .cin  (chain_q),
    .sub  (op_q),
    .sum  (sum_word),
    .cout (cout_w)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = EXEC;
      EXEC:    if (last_w)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; done is registered so it lands one cycle after DONE.
  always_comb begin
    busy_w = (state_q == EXEC);
    done_d = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    nw_d     = nw_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    chain_d  = chain_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op_sub;
          nw_d     = bus.nwords;
          a_d      = bus.a_in;
          b_d      = bus.b_in;
          idx_d    = '0;
          chain_d  = bus.op_sub;
          result_d = '0;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      EXEC: begin
        result_d[int'(idx_q)*WORD_W +: WORD_W] = sum_word;
        chain_d = cout_w;
        idx_d   = idx_q + 1'b1;
        if (last_w) begin
          carry_d = cout_w;
          ovf_d   = ovf_w;
`ifdef MULTIWORD_ARITH_CTRL_SAT_EN
          if (ovf_w) result_d = sat_value(nw_q, a_word[WORD_W-1]);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 1'b0;
      nw_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      nw_q     <= nw_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_w;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;

endmodule
